// File: rtl/surf_debug_pkg.sv
// Shared definitions for the SURF debug capture multiplexer: state encoding and
// a constant-evaluable ceil(log2) helper used to size pointers.
package surf_debug_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } cap_state_e;

  // Smallest n with 2**n >= value; used at elaboration time only.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/surf_debug_capture_ram.sv
// Capture buffer: DEPTH x WIDTH simple dual-port RAM, one write port and one
// registered read port, written so that it maps onto a block RAM.
module surf_debug_capture_ram
  import surf_debug_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 35,
  parameter int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Output register carries the reset so the readout port starts at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/surf_debug_capture_mux.sv
// Parametrised debug bus multiplexer with a triggered circular capture buffer
// (pre-trigger history) and a strobe-driven readout port.
module surf_debug_capture_mux
  import surf_debug_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned WIDTH  = 35,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NCH*WIDTH-1:0]   in_i,
  input  logic [SEL_W-1:0]       sel_i,
  output logic [WIDTH-1:0]       mux_o,
  input  logic                   arm_i,
  input  logic                   abort_i,
  input  logic [WIDTH-1:0]       trig_mask_i,
  input  logic [WIDTH-1:0]       trig_val_i,
  input  logic [ADDR_W-1:0]      pretrig_i,
  output logic [STATE_W-1:0]     state_o,
  output logic [ADDR_W-1:0]      trig_addr_o,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   rd_valid_o
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  cap_state_e         r_state;
  logic [WIDTH-1:0]   r_mux;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_pre_cnt;
  logic [PTR_W-1:0]   r_post_cnt;
  logic [PTR_W-1:0]   r_pre_len;
  logic [WIDTH-1:0]   r_mask;
  logic [WIDTH-1:0]   r_val;
  logic [ADDR_W-1:0]  r_trig_addr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_rd_cnt;
  logic               r_rd_valid;

  cap_state_e         w_state_nxt;
  logic [WIDTH-1:0]   w_sel;
  logic [PTR_W-1:0]   w_pre_clamp;
  logic               w_hit;
  logic               w_we;
  logic               w_rd_fire;
  logic [PTR_W-1:0]   w_wr_ptr_nxt;
  logic [PTR_W-1:0]   w_pre_cnt_nxt;
  logic [PTR_W-1:0]   w_post_cnt_nxt;
  logic [PTR_W-1:0]   w_pre_len_nxt;
  logic [WIDTH-1:0]   w_mask_nxt;
  logic [WIDTH-1:0]   w_val_nxt;
  logic [ADDR_W-1:0]  w_trig_addr_nxt;
  logic [PTR_W-1:0]   w_rd_ptr_nxt;
  logic [CNT_W-1:0]   w_rd_cnt_nxt;

  // Channel select; out-of-range selects give zero.
  always_comb begin
    w_sel = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (32'(sel_i) == k) w_sel = in_i[k*WIDTH +: WIDTH];
    end
  end

  // Pre-trigger length can never consume the whole buffer.
  always_comb begin
    if (32'(pretrig_i) > (DEPTH - 1)) w_pre_clamp = LAST_IDX;
    else                              w_pre_clamp = PTR_W'(pretrig_i);
  end

  assign w_hit = ((r_mux & r_mask) == (r_val & r_mask));

  // Next-state and datapath control for the capture / readout sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_we            = 1'b0;
    w_rd_fire       = 1'b0;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_pre_cnt_nxt   = r_pre_cnt;
    w_post_cnt_nxt  = r_post_cnt;
    w_pre_len_nxt   = r_pre_len;
    w_mask_nxt      = r_mask;
    w_val_nxt       = r_val;
    w_trig_addr_nxt = r_trig_addr;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_rd_cnt_nxt    = r_rd_cnt;

    case (r_state)
      ST_IDLE: begin
        if (arm_i) begin
          w_pre_len_nxt = w_pre_clamp;
          w_mask_nxt    = trig_mask_i;
          w_val_nxt     = trig_val_i;
          w_wr_ptr_nxt  = '0;
          w_pre_cnt_nxt = '0;
          w_rd_cnt_nxt  = '0;
          w_state_nxt   = (w_pre_clamp == '0) ? ST_ARMED : ST_PRE;
        end
      end

      ST_PRE: begin
        w_we          = 1'b1;
        w_wr_ptr_nxt  = r_wr_ptr + PTR_W'(1);
        w_pre_cnt_nxt = r_pre_cnt + PTR_W'(1);
        if ((r_pre_cnt + PTR_W'(1)) == r_pre_len) w_state_nxt = ST_ARMED;
      end

      ST_ARMED: begin
        w_we         = 1'b1;
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
        if (w_hit) begin
          w_trig_addr_nxt = ADDR_W'(r_wr_ptr);
          w_rd_ptr_nxt    = r_wr_ptr - r_pre_len;
          w_post_cnt_nxt  = LAST_IDX - r_pre_len;
          w_state_nxt     = (r_pre_len == LAST_IDX) ? ST_DONE : ST_POST;
        end
      end

      ST_POST: begin
        if (r_post_cnt == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_we           = 1'b1;
          w_wr_ptr_nxt   = r_wr_ptr + PTR_W'(1);
          w_post_cnt_nxt = r_post_cnt - PTR_W'(1);
        end
      end

      ST_DONE: begin
        // Leave only once the final word has already been presented.
        if (r_rd_cnt == CNT_W'(DEPTH)) begin
          w_state_nxt = ST_IDLE;
        end else if (rd_en_i) begin
          w_rd_fire    = 1'b1;
          w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
          w_rd_cnt_nxt = r_rd_cnt + CNT_W'(1);
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    if (abort_i) begin
      w_state_nxt     = ST_IDLE;
      w_we            = 1'b0;
      w_rd_fire       = 1'b0;
      w_trig_addr_nxt = r_trig_addr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_mux       <= '0;
      r_wr_ptr    <= '0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_pre_len   <= '0;
      r_mask      <= '0;
      r_val       <= '0;
      r_trig_addr <= '0;
      r_rd_ptr    <= '0;
      r_rd_cnt    <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mux       <= w_sel;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_pre_cnt   <= w_pre_cnt_nxt;
      r_post_cnt  <= w_post_cnt_nxt;
      r_pre_len   <= w_pre_len_nxt;
      r_mask      <= w_mask_nxt;
      r_val       <= w_val_nxt;
      r_trig_addr <= w_trig_addr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_rd_cnt    <= w_rd_cnt_nxt;
      r_rd_valid  <= w_rd_fire;
    end
  end

  surf_debug_capture_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (r_mux),
    .i_re    (w_rd_fire),
    .i_raddr (r_rd_ptr),
    .o_rdata (rd_data_o)
  );

  assign mux_o       = r_mux;
  assign state_o     = r_state;
  assign trig_addr_o = r_trig_addr;
  assign rd_valid_o  = r_rd_valid;

endmodule

// File: tb/tb_surf_debug_capture_mux.sv
// Scoreboard bench: stimulus pushes expectations, a negedge monitor compares
// them against the DUT, using a sample-stream model of capture and readout.
module tb_surf_debug_capture_mux;

  localparam int unsigned NCH    = 4;
  localparam int unsigned W      = 35;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 8;

  typedef enum int {K_STATE, K_TADDR, K_VALCNT, K_RDV0, K_RST, K_DRAIN, K_TIMEOUT, K_NOTRIG} kind_e;
  typedef struct {
    kind_e       kind;
    logic [63:0] exp;
  } chk_t;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic [NCH*W-1:0]     in_i;
  logic [SEL_W-1:0]     sel_i;
  logic                 arm_i, abort_i, rd_en_i;
  logic [W-1:0]         trig_mask_i, trig_val_i;
  logic [ADDR_W-1:0]    pretrig_i;
  logic [W-1:0]         mux_o, rd_data_o, mux3_o, rd3;
  logic [2:0]           state_o, st3;
  logic [ADDR_W-1:0]    trig_addr_o, ta3;
  logic                 rd_valid_o, rv3;

  logic [W-1:0]         samp_all[$];
  logic [W-1:0]         exp_rd_q[$];
  chk_t                 chk_q[$];
  logic [W-1:0]         mdl_mux = '0, mdl_mux3 = '0;
  bit                   mon_en = 1'b0;
  int unsigned          n_cmp = 0, n_fail = 0, n_valid = 0;
  int unsigned          last_trig = 0;

  always #5 clk = ~clk;

  surf_debug_capture_mux #(.NCH(NCH), .WIDTH(W), .SEL_W(SEL_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .in_i(in_i), .sel_i(sel_i), .mux_o(mux_o),
    .arm_i(arm_i), .abort_i(abort_i), .trig_mask_i(trig_mask_i), .trig_val_i(trig_val_i),
    .pretrig_i(pretrig_i), .state_o(state_o), .trig_addr_o(trig_addr_o),
    .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o));

  // Three-channel instance: only its mux path is exercised.
  surf_debug_capture_mux #(.NCH(3), .WIDTH(W), .SEL_W(SEL_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut3 (
    .clk_i(clk), .rst_i(rst_i), .in_i(in_i[3*W-1:0]), .sel_i(sel_i), .mux_o(mux3_o),
    .arm_i(1'b0), .abort_i(1'b0), .trig_mask_i(trig_mask_i), .trig_val_i(trig_val_i),
    .pretrig_i(pretrig_i), .state_o(st3), .trig_addr_o(ta3),
    .rd_en_i(1'b0), .rd_data_o(rd3), .rd_valid_o(rv3));

  function automatic logic [W-1:0] chan_of(input logic [NCH*W-1:0] bus, input int s, input int nch);
    if (s >= nch) return '0;
    return bus[s*W +: W];
  endfunction

  // Reference: the sample presented at each edge is the channel chosen one cycle earlier.
  always @(posedge clk) begin
    samp_all.push_back(chan_of(in_i, int'(sel_i), NCH));
    mdl_mux  <= rst_i ? '0 : chan_of(in_i, int'(sel_i), NCH);
    mdl_mux3 <= rst_i ? '0 : chan_of(in_i, int'(sel_i), 3);
  end

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk_t c;
    if (mon_en) begin
      cmp("mux", 64'(mux_o), 64'(mdl_mux));
      cmp("mux_nch3", 64'(mux3_o), 64'(mdl_mux3));
      cmp("idle_instance", 64'({st3, rv3, ta3, rd3}), 64'd0);
      if (rd_valid_o === 1'b1) begin
        n_valid++;
        if (exp_rd_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rd_valid: got 1 with data %0h, required 0 (no word pending)", rd_data_o);
        end else begin
          cmp("rd_data", 64'(rd_data_o), 64'(exp_rd_q.pop_front()));
        end
      end
      while (chk_q.size() != 0) begin
        c = chk_q.pop_front();
        case (c.kind)
          K_STATE:  cmp("state", 64'(state_o), c.exp);
          K_TADDR:  cmp("trig_addr", 64'(trig_addr_o), c.exp);
          K_VALCNT: cmp("valid_count", 64'(n_valid), c.exp);
          K_RDV0:   cmp("rd_valid_idle", 64'(rd_valid_o), 64'd0);
          K_DRAIN:  cmp("rd_words_left", 64'(exp_rd_q.size()), c.exp);
          K_RST: begin
            cmp("rst_mux", 64'(mux_o), 64'd0);
            cmp("rst_state", 64'(state_o), 64'd0);
            cmp("rst_trig_addr", 64'(trig_addr_o), 64'd0);
            cmp("rst_rd_data", 64'(rd_data_o), 64'd0);
            cmp("rst_rd_valid", 64'(rd_valid_o), 64'd0);
          end
          K_TIMEOUT: begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: waited %0d cycles in state %0d, required progress", c.exp, state_o);
          end
          default: begin
            n_cmp++;
            n_fail++;
            $display("FAIL trigger: DUT reached DONE but no sample matched, required a hit (%0d samples)", c.exp);
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_chk(input kind_e k, input logic [63:0] e);
    chk_t c;
    c.kind = k;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  task automatic drive_random();
    for (int k = 0; k < NCH; k++) in_i[k*W +: W] = W'({$urandom(), $urandom()});
    if ($urandom_range(0, 3) == 0) sel_i = SEL_W'($urandom());
  endtask

  // Arm, run until DONE, then predict trig_addr and the full readout.
  task automatic run_capture(input int unsigned pt, input logic [W-1:0] mask,
                             input logic [W-1:0] val, input bit counter_mode);
    int unsigned base, pre, t, cyc;
    logic [W-1:0] ctr;
    bit found;
    pretrig_i   = ADDR_W'(pt);
    trig_mask_i = mask;
    trig_val_i  = val;
    ctr = '0;
    if (counter_mode) in_i[int'(sel_i)*W +: W] = ctr;
    else drive_random();
    arm_i = 1'b1;
    base  = samp_all.size();
    tick();
    arm_i = 1'b0;
    cyc = 0;
    while (state_o != 3'd4 && cyc < 3000) begin
      if (counter_mode) begin
        ctr = ctr + W'(1);
        in_i[int'(sel_i)*W +: W] = ctr;
      end else begin
        drive_random();
        trig_mask_i = W'({$urandom(), $urandom()});
        trig_val_i  = W'({$urandom(), $urandom()});
      end
      tick();
      cyc++;
    end
    if (state_o != 3'd4) begin
      push_chk(K_TIMEOUT, 64'(cyc));
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      return;
    end
    pre = (pt > DEPTH - 1) ? DEPTH - 1 : pt;
    found = 1'b0;
    t = 0;
    for (int i = int'(base + pre); i < samp_all.size(); i++) begin
      if (!found && (((samp_all[i] ^ val) & mask) == '0)) begin
        found = 1'b1;
        t = i - base;
      end
    end
    if (!found) begin
      push_chk(K_NOTRIG, 64'(samp_all.size() - base));
      return;
    end
    for (int j = 0; j < DEPTH; j++) exp_rd_q.push_back(samp_all[base + t - pre + j]);
    last_trig = t % DEPTH;
    push_chk(K_TADDR, 64'(last_trig));
  endtask

  task automatic readout(input bit hold);
    int unsigned v0, cyc;
    v0 = n_valid;
    if (hold) begin
      rd_en_i = 1'b1;
      repeat (20) tick();
    end else begin
      cyc = 0;
      while (n_valid < v0 + DEPTH && cyc < 300) begin
        rd_en_i = ($urandom_range(0, 1) == 1);
        tick();
        cyc++;
      end
      rd_en_i = 1'b0;
      tick();
    end
    rd_en_i = 1'b0;
    tick();
    push_chk(K_VALCNT, 64'(v0 + DEPTH));
    push_chk(K_STATE, 64'd0);
  endtask

  initial begin
    int unsigned cyc;
    logic [W-1:0] m;
    rst_i = 1'b1; in_i = '0; sel_i = '0; arm_i = 1'b0; abort_i = 1'b0;
    trig_mask_i = '0; trig_val_i = '0; pretrig_i = '0; rd_en_i = 1'b0;
    repeat (3) tick();
    mon_en = 1'b1;
    push_chk(K_RST, 64'd0);
    rst_i = 1'b0;

    // Mux sweep over fixed channel values.
    for (int k = 0; k < NCH; k++) in_i[k*W +: W] = W'(k + 1);
    for (int s = 0; s < 4; s++) begin
      sel_i = SEL_W'(s);
      tick();
      tick();
    end

    // Counter on channel 1, trigger on value 100 with 4 pre-trigger samples.
    sel_i = SEL_W'(1);
    run_capture(4, {W{1'b1}}, W'(100), 1'b1);
    readout(1'b1);

    // Outside DONE the read strobe must not produce data.
    rd_en_i = 1'b1;
    repeat (3) begin
      tick();
      push_chk(K_RDV0, 64'd0);
    end
    rd_en_i = 1'b0;

    run_capture(0, '0, W'($urandom()), 1'b0);
    readout(1'b0);
    run_capture(255, '0, '0, 1'b0);
    readout(1'b1);

    for (int it = 0; it < 6; it++) begin
      m = W'($urandom_range(1, 7)) << $urandom_range(0, 32);
      run_capture($urandom_range(0, 20), m, W'({$urandom(), $urandom()}), 1'b0);
      readout(it[0]);
    end

    // Abort coinciding with a matching trigger on the first ARMED cycle.
    pretrig_i = ADDR_W'(2); trig_mask_i = '0;
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    cyc = 0;
    while (state_o != 3'd2 && cyc < 20) begin tick(); cyc++; end
    if (state_o != 3'd2) push_chk(K_TIMEOUT, 64'(cyc));
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    push_chk(K_STATE, 64'd0);
    push_chk(K_TADDR, 64'(last_trig));
    tick();
    push_chk(K_STATE, 64'd0);

    // Synchronous reset in the middle of POST.
    pretrig_i = ADDR_W'(2); trig_mask_i = '0;
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    cyc = 0;
    while (state_o != 3'd3 && cyc < 20) begin tick(); cyc++; end
    if (state_o != 3'd3) push_chk(K_TIMEOUT, 64'(cyc));
    rst_i = 1'b1;
    tick();
    push_chk(K_RST, 64'd0);
    rst_i = 1'b0;
    tick();

    // Recovery after reset.
    run_capture(3, W'(3), W'($urandom_range(0, 3)), 1'b0);
    readout(1'b0);

    tick();
    push_chk(K_DRAIN, 64'd0);
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
